mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32 pipeline. It consumes the EX/MEM pipeline register outputs (ALU result, PC, rs2, rd, WBsel, RegWEn, memRW) and performs word loads and stores over a req/ack data-memory bus. While an access waits on the bus, it stalls the upstream pipeline and inserts bubbles into the MEM/WB register. It also selects the writeback value and registers the MEM/WB outputs for the WB stage.

## Interface
- TIMEOUT, 16: maximum number of cycles in BUSY before the access is abandoned; range 1..255.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_alu  in  32  ALU result from EX/MEM; the memory address for loads and stores
- in_pc  in  32  instruction PC from EX/MEM
- in_rs2  in  32  store data from EX/MEM
- in_rd  in  5  destination register
- in_wbsel  in  2  writeback select: 0 = mem, 1 = alu, 2 = pc+4, 3 = alu (reserved)
- in_regwen  in  1  register write enable
- in_memrw  in  1  1 = store
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe, qualified by dmem_req
- dmem_addr  out  32  word address; bits [1:0] always 0
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, sampled in the ack cycle
- dmem_ack  in  1  access complete; may be asserted in the same cycle as req
- stall  out  1  upstream must hold EX/MEM and earlier stages this cycle
- wb_data  out  32  registered writeback value
- wb_rd  out  5  registered rd
- wb_regwen  out  1  registered write enable
- misalign  out  1  registered one-cycle pulse: a misaligned access was suppressed
- bus_err  out  1  registered one-cycle pulse: TIMEOUT expired

## Operation
- Access classification:
  - load = in_regwen && in_wbsel==0
  - store = in_memrw
  - access = load || store
  - aligned = in_alu[1:0]==0
- A bubble (all inputs 0) is not an access.
- If an instruction is both a load and a store, it is a store; the load returns rdata.
- FSM states: IDLE and BUSY.
- IDLE:
  - dmem_req = access && aligned, driven combinationally from the inputs.
  - If dmem_ack is also high, the access completes this cycle with no stall.
  - If dmem_ack is low: stall=1, latch addr, wdata and we into internal registers, then go to BUSY.
- BUSY:
  - dmem_req=1; addr, wdata and we are driven from the latched registers and stay stable until ack.
  - stall = !dmem_ack.
  - On ack: complete, go to IDLE.
- Timeout counter:
  - 8 bits, cleared on entry to BUSY, increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack: dmem_req drops next cycle, bus_err pulses, the instruction's writeback is suppressed (wb_regwen=0), FSM returns to IDLE, stall is released.
- Misaligned access (access && !aligned):
  - No dmem_req.
  - misalign pulses on the next cycle.
  - MEM/WB captures a bubble; no stall.
- MEM/WB register, updated every rising edge:
  - When stall=1: captures a bubble (wb_data=0, wb_rd=0, wb_regwen=0).
  - Otherwise captures:
    - wb_data = sel(in_wbsel: rdata / in_alu / in_pc+4 / in_alu); pc+4 uses modulo-2^32 add.
    - wb_rd = in_rd.
    - wb_regwen = in_regwen && !suppressed.
- Stores complete silently; their wb_regwen follows in_regwen, which is normally 0 for stores.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, latched bus regs=0, all registered outputs 0.
- dmem_req is combinational from inputs in IDLE, so it falls immediately on rst.
- Reset asserted mid-BUSY abandons the access; no bus_err is raised.
- Zero-wait access: instruction enters EX/MEM in cycle N with ack in N; wb_* valid in N+1; stall never asserted.
- k-wait access: stall is high in cycles N..N+k-1; ack arrives in N+k; wb_* valid in N+k+1; bubbles appear on wb_* during N+1..N+k.
- Back-to-back accesses: the FSM returns to IDLE in the ack cycle, so the next instruction may issue req in the following cycle.
- Timeout: stall is high for exactly TIMEOUT cycles; bus_err and the suppressed writeback appear in the cycle after.
- An ack that arrives in the same cycle the timeout fires wins: the access completes normally and no bus_err is raised.

## Structure
- Shared package rv_pkg holds:
  - WBSEL_MEM=2'd0, WBSEL_ALU=2'd1, WBSEL_PC4=2'd2
  - the mem-stage state encoding (IDLE=0, BUSY=1)
- Sub-module mem_wb_reg: the MEM/WB register with async reset and a synchronous bubble input driven by stall or suppression.
- The FSM, timeout counter and writeback mux live in mem_stage.

## Test plan
- Zero-wait load, ack tied to req, alu=0x100, rd=5, rdata=0xDEADBEEF -> dmem_addr=0x100, stall=0 throughout, next cycle wb_data=0xDEADBEEF, wb_rd=5, wb_regwen=1.
- Store with ack after 3 cycles, alu=0x40, rs2=0x12345678 -> dmem_we=1, addr and wdata stable for 4 cycles, stall=1 for 3 cycles, 3 bubbles on wb_regwen, then wb_regwen=0.
- Misaligned load, alu=0x102 -> dmem_req stays 0, misalign=1 for one cycle, wb_regwen=0, stall=0.
- TIMEOUT=4 with no ack -> stall=1 for 4 cycles, dmem_req drops, bus_err=1 for one cycle, wb_regwen=0.
- ALU and pc+4 writeback: wbsel=1 with alu=7 -> wb_data=7; wbsel=2 with pc=0xFFFFFFFC -> wb_data=0x00000000.
- rst asserted in the 2nd BUSY cycle -> dmem_req=0 and stall=0 immediately, all wb_* 0, no bus_err; a new load after release completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 pipeline types and constants.
// Writeback selects, MEM/WB bundle and mem-stage state encoding.
package rv_pkg;

    localparam logic [1:0] WBSEL_MEM = 2'd0;
    localparam logic [1:0] WBSEL_ALU = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwen;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
// Loads a bubble whenever the stage does not complete an instruction.
module mem_wb_reg
    import rv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // capture the next writeback bundle, or zeros for a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage.
// Word loads/stores over req/ack, stall on wait, timeout, MEM/WB mux.
module mem_stage
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wbsel,
    input  logic        in_regwen,
    input  logic        in_memrw,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwen,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mem_state_e  state;
    mem_state_e  state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic        is_load;
    logic        is_store;
    logic        access;
    logic        aligned;
    logic        issue;
    logic        bad_align;
    logic        go_busy;
    logic        timeout;
    logic        bubble;
    mem_wb_t     wb_d;
    mem_wb_t     wb_q;

    // classify the instruction sitting in EX/MEM
    always_comb begin
        is_load   = in_regwen && (in_wbsel == WBSEL_MEM);
        is_store  = in_memrw;
        access    = is_load || is_store;
        aligned   = (in_alu[1:0] == 2'b00);
        issue     = access && aligned;
        bad_align = access && !aligned && (state == MEM_IDLE);
    end

    // bus FSM: next state, counter, bus drive and stall
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = {in_alu[31:2], 2'b00};
        dmem_wdata = in_rs2;
        stall      = 1'b0;
        go_busy    = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            MEM_IDLE: begin
                dmem_req = issue;
                dmem_we  = issue && is_store;
                if (issue && !dmem_ack) begin
                    stall    = 1'b1;
                    go_busy  = 1'b1;
                    cnt_nx   = 8'd0;
                    state_nx = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                if (dmem_ack) begin
                    state_nx = MEM_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout  = 1'b1;
                    state_nx = MEM_IDLE;
                end else begin
                    stall  = 1'b1;
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = MEM_IDLE;
        endcase
        // bus and upstream must see the stage idle while in reset
        if (rst) begin
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            stall    = 1'b0;
        end
    end

    // state, timeout counter and the held bus request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MEM_IDLE;
            cnt     <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (go_busy) begin
                addr_q  <= {in_alu[31:2], 2'b00};
                wdata_q <= in_rs2;
                we_q    <= is_store;
            end
        end
    end

    // writeback value select
    always_comb begin
        wb_d.rd     = in_rd;
        wb_d.regwen = in_regwen;
        unique case (in_wbsel)
            WBSEL_MEM: wb_d.data = dmem_rdata;
            WBSEL_ALU: wb_d.data = in_alu;
            WBSEL_PC4: wb_d.data = in_pc + 32'd4;
            default:   wb_d.data = in_alu;
        endcase
    end

    assign bubble = stall || timeout || bad_align;

    mem_wb_reg u_mem_wb (
        .clk    (clk),
        .rst    (rst),
        .bubble (bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wb_data   = wb_q.data;
    assign wb_rd     = wb_q.rd;
    assign wb_regwen = wb_q.regwen;

    // one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            misalign <= bad_align;
            bus_err  <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table plus randomized instructions for mem_stage.
// Expectations come from per-instruction timing rules, not from the RTL.
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_alu, in_pc, in_rs2;
    logic [4:0]  in_rd;
    logic [1:0]  in_wbsel;
    logic        in_regwen, in_memrw;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwen, misalign, bus_err;

    mem_stage #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_alu     (in_alu),
        .in_pc      (in_pc),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_wbsel   (in_wbsel),
        .in_regwen  (in_regwen),
        .in_memrw   (in_memrw),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .stall      (stall),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_regwen  (wb_regwen),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, pc, rs2, rdata;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic        regwen, memrw;
        int          waits;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_we, e_mis, e_err, e_pay;
        int          e_stalls;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_we, exp_mis, exp_err, exp_pay;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".wb_regwen"}, 32'(wb_regwen), 32'(exp_we));
        chk({tag, ".misalign"}, 32'(misalign), 32'(exp_mis));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
        if (exp_pay) begin
            chk({tag, ".wb_data"}, wb_data, exp_data);
            chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(exp_rd));
        end
    endtask

    task automatic exp_bubble();
        exp_data = 32'd0;
        exp_rd   = 5'd0;
        exp_we   = 1'b0;
        exp_mis  = 1'b0;
        exp_err  = 1'b0;
        exp_pay  = 1'b1;
    endtask

    function automatic vec_t mk(
        input logic [31:0] alu, input logic [31:0] pc,
        input logic [31:0] rs2, input logic [31:0] rdata,
        input logic [4:0] rd, input logic [1:0] wbsel,
        input logic regwen, input logic memrw, input int waits,
        input logic [31:0] e_data, input logic [4:0] e_rd,
        input logic e_we, input logic e_mis, input logic e_err,
        input logic e_pay, input int e_stalls);
        vec_t v;
        v.alu = alu; v.pc = pc; v.rs2 = rs2; v.rdata = rdata;
        v.rd = rd; v.wbsel = wbsel; v.regwen = regwen;
        v.memrw = memrw; v.waits = waits;
        v.e_data = e_data; v.e_rd = e_rd; v.e_we = e_we;
        v.e_mis = e_mis; v.e_err = e_err; v.e_pay = e_pay;
        v.e_stalls = e_stalls;
        return v;
    endfunction

    function automatic logic [31:0] wb_pick(input vec_t v);
        if (v.wbsel == 2'd0) return v.rdata;
        if (v.wbsel == 2'd2) return v.pc + 32'd4;
        return v.alu;
    endfunction

    // reference outcome of one instruction from the stage's rules
    function automatic vec_t model(input vec_t v);
        bit acc;
        bit al;
        acc = (v.regwen && v.wbsel == 2'd0) || v.memrw;
        al  = (v.alu[1:0] == 2'b00);
        v.e_mis = 1'b0; v.e_err = 1'b0; v.e_pay = 1'b1; v.e_stalls = 0;
        if (acc && !al) begin
            v.e_mis = 1'b1; v.e_data = 32'd0; v.e_rd = 5'd0; v.e_we = 1'b0;
        end else if (acc && v.waits > T) begin
            v.e_err = 1'b1; v.e_we = 1'b0; v.e_pay = 1'b0;
            v.e_data = 32'd0; v.e_rd = 5'd0; v.e_stalls = T;
        end else begin
            v.e_stalls = acc ? v.waits : 0;
            v.e_data = wb_pick(v);
            v.e_rd = v.rd;
            v.e_we = v.regwen;
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_alu = v.alu; in_pc = v.pc; in_rs2 = v.rs2; in_rd = v.rd;
        in_wbsel = v.wbsel; in_regwen = v.regwen; in_memrw = v.memrw;
        dmem_rdata = v.rdata;
    endtask

    // hold one instruction in EX/MEM until the stage releases it
    task automatic run_instr(input vec_t v, input string tag);
        bit acc, issue;
        int len;
        int stalls;
        acc = (v.regwen && v.wbsel == 2'd0) || v.memrw;
        issue = acc && (v.alu[1:0] == 2'b00);
        len = !issue ? 1 : (v.waits > T ? T + 1 : v.waits + 1);
        stalls = 0;
        for (int c = 0; c < len; c++) begin
            drive(v);
            dmem_ack = issue && (c == v.waits);
            @(negedge clk);
            check_regs(tag);
            chk({tag, ".req"}, 32'(dmem_req), 32'(issue));
            chk({tag, ".stall"}, 32'(stall), 32'(issue && c < len - 1));
            if (stall) stalls++;
            if (issue) begin
                chk({tag, ".addr"}, dmem_addr, v.alu);
                chk({tag, ".we"}, 32'(dmem_we), 32'(v.memrw));
                if (v.memrw) chk({tag, ".wdata"}, dmem_wdata, v.rs2);
            end
            @(posedge clk);
            #1;
            if (c == len - 1) begin
                exp_data = v.e_data; exp_rd = v.e_rd; exp_we = v.e_we;
                exp_mis = v.e_mis; exp_err = v.e_err; exp_pay = v.e_pay;
            end else begin
                exp_bubble();
            end
        end
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(v.e_stalls));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        tbl[0] = mk(32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 2'd0, 1, 0, 0,
                    32'hDEADBEEF, 5'd5, 1, 0, 0, 1, 0);
        tbl[1] = mk(32'h40, 32'h8, 32'h12345678, 32'h0, 5'd0, 2'd1, 0, 1, 3,
                    32'h40, 5'd0, 0, 0, 0, 1, 3);
        tbl[2] = mk(32'h102, 32'h10, 32'h0, 32'h55, 5'd7, 2'd0, 1, 0, 0,
                    32'h0, 5'd0, 0, 1, 0, 1, 0);
        tbl[3] = mk(32'h200, 32'h14, 32'h0, 32'h77, 5'd3, 2'd0, 1, 0, 99,
                    32'h0, 5'd0, 0, 0, 1, 0, 4);
        tbl[4] = mk(32'h7, 32'h18, 32'h0, 32'h99, 5'd9, 2'd1, 1, 0, 0,
                    32'h7, 5'd9, 1, 0, 0, 1, 0);
        tbl[5] = mk(32'h3, 32'hFFFFFFFC, 32'h0, 32'h99, 5'd1, 2'd2, 1, 0, 0,
                    32'h0, 5'd1, 1, 0, 0, 1, 0);
        tbl[6] = mk(32'h300, 32'h1C, 32'h0, 32'hCAFEF00D, 5'd4, 2'd0, 1, 0, 4,
                    32'hCAFEF00D, 5'd4, 1, 0, 0, 1, 4);
        tbl[7] = mk(32'h55, 32'h20, 32'h0, 32'h1, 5'd2, 2'd3, 1, 0, 0,
                    32'h55, 5'd2, 1, 0, 0, 1, 0);
        tbl[8] = mk(32'h80, 32'h24, 32'hAA, 32'h11112222, 5'd6, 2'd0, 1, 1, 1,
                    32'h11112222, 5'd6, 1, 0, 0, 1, 1);

        // reset: bus quiet even with a load presented, outputs cleared
        rst = 1'b1;
        dmem_ack = 1'b0;
        drive(tbl[0]);
        #3;
        chk("reset.req", 32'(dmem_req), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.wb_data", wb_data, 32'd0);
        chk("reset.wb_regwen", 32'(wb_regwen), 32'd0);
        chk("reset.bus_err", 32'(bus_err), 32'd0);
        drive(z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_bubble();

        foreach (tbl[i]) run_instr(tbl[i], $sformatf("tbl%0d", i));

        // reset in the second BUSY cycle abandons the access
        v = mk(32'h180, 32'h30, 32'h0, 32'h0, 5'd8, 2'd0, 1, 0, 99,
               0, 0, 0, 0, 0, 1, 0);
        drive(v);
        dmem_ack = 1'b0;
        @(negedge clk);
        check_regs("rstb.pre");
        chk("rstb.idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("rstb.busy_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstb.req", 32'(dmem_req), 32'd0);
        chk("rstb.stall", 32'(stall), 32'd0);
        chk("rstb.wb_data", wb_data, 32'd0);
        chk("rstb.wb_rd", 32'(wb_rd), 32'd0);
        chk("rstb.wb_regwen", 32'(wb_regwen), 32'd0);
        chk("rstb.misalign", 32'(misalign), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("rstb.bus_err", 32'(bus_err), 32'd0);
            chk("rstb.hold_req", 32'(dmem_req), 32'd0);
        end
        drive(z);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_bubble();
        run_instr(mk(32'h104, 32'h34, 32'h0, 32'h0BADF00D, 5'd12, 2'd0, 1, 0, 0,
                     32'h0BADF00D, 5'd12, 1, 0, 0, 1, 0), "rstb.after");

        // randomized instruction stream against the reference model
        for (int n = 0; n < 300; n++) begin
            v = z;
            v.alu = $urandom;
            if ($urandom_range(0, 4) != 0) v.alu[1:0] = 2'b00;
            v.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            v.rs2 = $urandom;
            v.rdata = $urandom;
            v.rd = 5'($urandom);
            v.wbsel = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom);
            v.regwen = 1'($urandom);
            v.memrw = ($urandom_range(0, 3) == 0);
            v.waits = $urandom_range(0, 6);
            v = model(v);
            run_instr(v, $sformatf("rnd%0d", n));
        end
        run_instr(model(z), "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
